hack_fetch: RTL and testbench
=============================

// Module: hack_fetch
// PURPOSE
//   Instruction-fetch stage of the Hack CPU. Holds the program counter,
//   requests instruction words from ROM over a req/ack handshake, and
//   presents each word on a valid/ready interface. The instruction bus
//   feeds the a input of the A-register input MUX16.
//   Jump targets come back from the execute stage on the same handshake.
// PARAMETERS
//   PC_W       15   ROM address / PC width (32K-word Hack ROM)
//   RESET_VEC  0    PC value loaded on reset
// PORTS
//   clk          in   1     system clock, all state on rising edge
//   reset        in   1     asynchronous, active-high reset
//   run          in   1     fetch enable; low parks the stage in IDLE
//   rom_req      out  1     ROM read request
//   rom_addr     out  PC_W  ROM word address, equals pc while rom_req=1
//   rom_ack      in   1     ROM read done; rom_data valid this cycle
//   rom_data     in   16    ROM read data
//   instr        out  16    fetched instruction word (to MUX16 a input)
//   instr_valid  out  1     instr holds an unconsumed word
//   instr_ready  in   1     execute stage accepts instr this cycle
//   jump         in   1     taken branch; sampled only on accept
//   jump_addr    in   PC_W  branch target; sampled only on accept
//   pc           out  PC_W  address of the word in instr / being fetched
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, pc=RESET_VEC, rom_req=0,
//     rom_addr=RESET_VEC, instr=16'h0000, instr_valid=0.
//     Reset mid-fetch drops rom_req at once; a late rom_ack is ignored.
//   States: IDLE, REQ, HOLD (registered; rom_req=1 only in REQ,
//     instr_valid=1 only in HOLD).
//   IDLE: run=1 -> REQ next cycle. run=0 -> stay.
//   REQ: rom_req=1, rom_addr=pc, both stable until ack.
//     rom_ack=1 -> instr<=rom_data, state<=HOLD. Valid rises the cycle
//     after ack. No ack -> wait indefinitely, no timeout.
//     run falling during REQ has no effect; the fetch completes.
//   HOLD: instr and pc stable until accepted.
//     Accept = instr_valid & instr_ready.
//     On accept: pc<=jump ? jump_addr : pc+1 (mod 2^PC_W, 7FFF->0000).
//     Also on accept: state<=REQ if run=1, else IDLE.
//     No accept -> jump/jump_addr ignored, state held.
//   Throughput: accept in cycle M -> rom_req with new pc in M+1.
//     Zero-wait ROM gives 1 instruction per 2 cycles.
//   rom_ack outside REQ: ignored, no state change.
//   pc is never modified except on reset or accept.
// TESTING
//   1. Reset, run=1, ROM ack 1 cycle after req with data 16'h0010.
//      rom_addr=0, then instr=16'h0010 and instr_valid one cycle after
//      ack; ready=1 -> next rom_addr=1.
//   2. Sequential run of 4 words, ready tied 1, zero-wait ROM.
//      rom_addr sequence 0,1,2,3; valid every 2nd cycle.
//   3. Accept at pc=5 with jump=1, jump_addr=15'h0100.
//      Next rom_addr=0x100, pc=0x100. jump=1 without accept -> pc unchanged.
//   4. pc=15'h7FFF, accept without jump.
//      pc wraps to 0, rom_addr=0.
//   5. Backpressure: ready=0 for 5 cycles in HOLD.
//      instr, pc, valid stable; no rom_req.
//      ROM delays ack 3 cycles -> rom_addr stable, req held.
//   6. Reset asserted while rom_req=1, ack arrives next cycle.
//      rom_req=0 immediately, pc=0, ack ignored.
//      run=0 at accept -> IDLE, no further req.

Source files
------------

// File: rtl/hack_fetch.sv
// hack_fetch: Hack CPU instruction-fetch stage.
// Holds pc, reads ROM over req/ack, presents words over valid/ready.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   run                   fetch enable (low parks the stage in IDLE)
//   rom_req, rom_addr     ROM read request and word address (= pc)
//   rom_ack, rom_data     ROM read done and read data
//   instr, instr_valid    fetched word (to A-register MUX16 a input)
//   instr_ready           execute stage accepts instr this cycle
//   jump, jump_addr       taken branch and target, used only on accept
//   pc                    address of the word held / being fetched
module hack_fetch #(
   parameter int              PC_W      = 15,
   parameter logic [PC_W-1:0] RESET_VEC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   output logic            rom_req,
   output logic [PC_W-1:0] rom_addr,
   input  logic            rom_ack,
   input  logic [15:0]     rom_data,
   output logic [15:0]     instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_addr,
   output logic [PC_W-1:0] pc
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            accept;
   logic            load;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_nx;
   logic [15:0]     instr_q;

   // State register; reset drops rom_req immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (run) state_nx = REQ;
         end
         REQ: begin
            // run is ignored here: a started fetch always completes.
            if (rom_ack) state_nx = HOLD;
         end
         HOLD: begin
            if (accept) state_nx = run ? REQ : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output decode from the registered state.
   always_comb begin
      rom_req     = 1'b0;
      instr_valid = 1'b0;
      unique case (state)
         IDLE: ;
         REQ:  rom_req = 1'b1;
         HOLD: instr_valid = 1'b1;
         default: ;
      endcase
   end

   assign accept = instr_valid & instr_ready;
   // rom_ack only counts while a request is outstanding.
   assign load   = rom_req & rom_ack;

   // Natural PC_W-bit wrap gives 7FFF -> 0000.
   assign pc_nx = jump ? jump_addr : pc_q + PC_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_VEC;
         instr_q <= 16'h0000;
      end else begin
         if (accept) pc_q <= pc_nx;
         if (load) instr_q <= rom_data;
      end
   end

   assign pc       = pc_q;
   assign rom_addr = pc_q;
   assign instr    = instr_q;

endmodule

// File: tb/tb_hack_fetch.sv
// tb_hack_fetch: self-checking bench for hack_fetch.
// Directed steps plus a randomized fetch/accept/jump run against a pc model.
module tb_hack_fetch;

   localparam int PC_W = 15;
   localparam logic [PC_W-1:0] MASK = '1;

   logic            clk = 1'b0;
   logic            reset;
   logic            run;
   logic            rom_req;
   logic [PC_W-1:0] rom_addr;
   logic            rom_ack;
   logic [15:0]     rom_data;
   logic [15:0]     instr;
   logic            instr_valid;
   logic            instr_ready;
   logic            jump;
   logic [PC_W-1:0] jump_addr;
   logic [PC_W-1:0] pc;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the address the stage should be working on,
   // and the word it should be holding.
   int          m_pc;
   logic [15:0] m_instr;

   hack_fetch #(.PC_W(PC_W), .RESET_VEC('0)) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .rom_req(rom_req),
      .rom_addr(rom_addr),
      .rom_ack(rom_ack),
      .rom_data(rom_data),
      .instr(instr),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .jump(jump),
      .jump_addr(jump_addr),
      .pc(pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_req"}, 32'(rom_req), 0);
      chk({tag, "_vld"}, 32'(instr_valid), 0);
      chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
   endtask

   // Entered one cycle into REQ; waits dly cycles, then acks with w.
   task automatic fetch(input string tag, input logic [15:0] w,
                        input int dly);
      chk({tag, "_req"}, 32'(rom_req), 1);
      chk({tag, "_addr"}, 32'(rom_addr), 32'(m_pc));
      chk({tag, "_vld0"}, 32'(instr_valid), 0);
      for (int i = 0; i < dly; i++) begin
         step();
         chk({tag, "_wreq"}, 32'(rom_req), 1);
         chk({tag, "_waddr"}, 32'(rom_addr), 32'(m_pc));
      end
      rom_ack  = 1'b1;
      rom_data = w;
      step();
      rom_ack  = 1'b0;
      rom_data = 16'($urandom);
      m_instr  = w;
      chk({tag, "_vld"}, 32'(instr_valid), 1);
      chk({tag, "_instr"}, 32'(instr), 32'(m_instr));
      chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
      chk({tag, "_noreq"}, 32'(rom_req), 0);
   endtask

   // n cycles of ready=0 in HOLD with jump noise and stray acks.
   task automatic stall(input string tag, input int n);
      instr_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         jump      = 1'($urandom);
         jump_addr = PC_W'($urandom);
         rom_ack   = 1'($urandom);
         rom_data  = 16'($urandom);
         step();
         chk({tag, "_vld"}, 32'(instr_valid), 1);
         chk({tag, "_instr"}, 32'(instr), 32'(m_instr));
         chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
         chk({tag, "_req"}, 32'(rom_req), 0);
      end
      jump    = 1'b0;
      rom_ack = 1'b0;
   endtask

   task automatic take(input string tag, input logic j,
                       input int tgt, input logic r);
      instr_ready = 1'b1;
      jump        = j;
      jump_addr   = PC_W'(tgt);
      run         = r;
      step();
      instr_ready = 1'b0;
      jump        = 1'b0;
      m_pc = j ? (tgt & MASK) : ((m_pc + 1) % (1 << PC_W));
      chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
      chk({tag, "_vld"}, 32'(instr_valid), 0);
      chk({tag, "_req"}, 32'(rom_req), 32'(r));
      if (r) chk({tag, "_addr"}, 32'(rom_addr), 32'(m_pc));
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; rom_ack = 1'b0; rom_data = 16'h0;
      instr_ready = 1'b0; jump = 1'b0; jump_addr = '0;
      m_pc = 0; m_instr = 16'h0;
      repeat (2) step();
      chk("rst_req", 32'(rom_req), 0);
      chk("rst_addr", 32'(rom_addr), 0);
      chk("rst_instr", 32'(instr), 0);
      chk("rst_vld", 32'(instr_valid), 0);
      chk("rst_pc", 32'(pc), 0);
      reset = 1'b0;
      step();
      chk_idle("idle");

      // 1: single fetch, 1-cycle ack, accept
      run = 1'b1;
      step();
      fetch("t1", 16'h0010, 0);
      take("t1acc", 1'b0, 0, 1'b1);

      // 2: four sequential words from 0, zero-wait ROM, ready 1
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_pc = 0; m_instr = 16'h0;
      chk_idle("t2rst");
      step();
      for (int i = 0; i < 4; i++) begin
         chk("t2_seq", 32'(rom_addr), 32'(i));
         fetch("t2", 16'($urandom), 0);
         take("t2acc", 1'b0, 0, 1'b1);
      end

      // 3: reach pc=5, jump ignored without accept, then jump
      fetch("t3a", 16'($urandom), 1);
      take("t3a_acc", 1'b0, 0, 1'b1);
      chk("t3_pc5", 32'(pc), 5);
      fetch("t3b", 16'($urandom), 0);
      instr_ready = 1'b0;
      jump = 1'b1;
      jump_addr = 15'h0100;
      repeat (2) step();
      chk("t3_nojmp", 32'(pc), 5);
      chk("t3_hold", 32'(instr_valid), 1);
      take("t3jmp", 1'b1, 'h0100, 1'b1);
      chk("t3_addr100", 32'(rom_addr), 'h100);

      // 4: wrap 7FFF -> 0
      fetch("t4a", 16'($urandom), 0);
      take("t4a_acc", 1'b1, 'h7FFF, 1'b1);
      fetch("t4b", 16'($urandom), 0);
      take("t4wrap", 1'b0, 0, 1'b1);
      chk("t4_pc0", 32'(pc), 0);

      // 5: 3-cycle ack delay, then 5 cycles of backpressure
      fetch("t5", 16'($urandom), 3);
      stall("t5bp", 5);

      // 6: run=0 at accept parks in IDLE; stray ack ignored
      take("t6park", 1'b0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         rom_ack = 1'b1;
         rom_data = 16'hDEAD;
         step();
         chk_idle("t6idle");
         chk("t6_instr", 32'(instr), 32'(m_instr));
      end
      rom_ack = 1'b0;
      run = 1'b1;
      step();
      chk("t6_req", 32'(rom_req), 1);
      chk("t6_addr", 32'(rom_addr), 32'(m_pc));
      #2 reset = 1'b1;
      #1;
      m_pc = 0; m_instr = 16'h0;
      chk("t6_rstreq", 32'(rom_req), 0);
      chk("t6_rstpc", 32'(pc), 0);
      step();
      reset = 1'b0;
      run = 1'b0;
      rom_ack = 1'b1;
      rom_data = 16'hBEEF;
      step();
      rom_ack = 1'b0;
      chk_idle("t6late");
      chk("t6_lateinstr", 32'(instr), 0);

      // Randomized: delays, backpressure, jumps, occasional wrap
      run = 1'b1;
      step();
      for (int n = 0; n < 150; n++) begin
         int  sel;
         int  tgt;
         fetch("rnd", 16'($urandom), $urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0)
            stall("rndbp", $urandom_range(1, 3));
         sel = $urandom_range(0, 9);
         tgt = (sel == 0) ? 'h7FFF : int'($urandom_range(0, 'h7FFF));
         take("rndacc", sel < 3, tgt, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
